pll_reset_sequencer: RTL and testbench
======================================

# pll_reset_sequencer

Sequences reset and lock qualification for the video/core PLL instance. Runs in the `refclk` domain (74.25 MHz), next to the PLL wrapper. Drives the PLL's `rst` input and samples its asynchronous `locked` output. Holds a core-wide reset until lock has been continuously stable, and re-sequences automatically on lock loss, timeout or a software restart request.

## Interface
Parameters:
- RST_CYCLES, default 16: cycles `pll_rst` is held high per sequence (≥2).
- STABLE_CYCLES, default 1024: consecutive synchronized-lock cycles required before release (≥2).
- TIMEOUT_CYCLES, default 742500: cycles allowed from `pll_rst` deassertion to release, 10 ms at 74.25 MHz (> STABLE_CYCLES).
- CNT_W, default 20: width of the shared down/up counter; must hold TIMEOUT_CYCLES.

Ports:
- refclk, in, 1: sole clock.
- rst, in, 1: synchronous, active-high reset.
- locked, in, 1: PLL lock, asynchronous to `refclk`.
- restart, in, 1: single-cycle request to re-sequence the PLL.
- pll_rst, out, 1: to PLL `rst`.
- core_reset, out, 1: active-high reset for downstream logic.
- ready, out, 1: equals `!core_reset`.
- lock_lost, out, 1: one-cycle pulse on lock loss while in RUN.
- retry_count, out, 8: timeouts since `rst`, saturates at 255.
- state, out, 2: debug encoding. RESET_PLL=0, WAIT_LOCK=1, STABILIZE=2, RUN=3.

## Operation
- `locked` passes through a 2-flop synchronizer. The result is `lock_s`, and only `lock_s` is used.
- Reset values: state RESET_PLL, `pll_rst`=1, `core_reset`=1, `ready`=0, `lock_lost`=0, `retry_count`=0, counters 0, synchronizer flops 0.
- RESET_PLL:
  - `pll_rst`=1, `core_reset`=1.
  - After RST_CYCLES cycles, go to WAIT_LOCK and clear `tmo_cnt`.
- WAIT_LOCK:
  - `pll_rst`=0.
  - `lock_s`=1 → STABILIZE with `stb_cnt`=0.
  - `tmo_cnt` increments each cycle.
- STABILIZE:
  - `stb_cnt` increments while `lock_s`=1.
  - `lock_s`=0 → WAIT_LOCK. `tmo_cnt` is not cleared.
  - `stb_cnt` reaching STABLE_CYCLES−1 with `lock_s`=1 → RUN.
  - `tmo_cnt` keeps incrementing.
- Timeout: `tmo_cnt` reaching TIMEOUT_CYCLES−1 in WAIT_LOCK or STABILIZE → RESET_PLL, and `retry_count` increments (saturating).
- RUN:
  - `core_reset`=0, `ready`=1.
  - `lock_s`=0 → `lock_lost` pulses for 1 cycle, go to RESET_PLL, `core_reset` reasserts.
- `restart`=1 in any state → RESET_PLL with the RST_CYCLES count reloaded. This restarts the count when already in RESET_PLL.
- Priority within one cycle: `rst` > `restart` > timeout > `lock_s` transitions.
  - `restart` coinciding with a timeout: no `retry_count` increment.
  - `restart` coinciding with lock loss in RUN: `lock_lost` still pulses.
  - Timeout and `lock_s` drop in the same cycle: the timeout is taken.
- `rst` mid-sequence returns everything to reset values. `retry_count` clears.

## Timing
- All outputs are registered. No combinational input-to-output paths.
- `pll_rst` is high during `rst` and for exactly RST_CYCLES cycles after the first cycle with `rst`=0.
- `locked` rising is visible as `lock_s` 2 cycles later.
- STABILIZE is entered 1 cycle after that.
- `ready` rises STABLE_CYCLES+3 cycles after the first edge sampling `locked`=1, provided lock holds.
- `locked` falling in RUN:
  - `lock_lost` and `core_reset` rise 3 cycles later (synchronizer plus state register).
  - `pll_rst` rises in the same cycle.
- `core_reset` and `ready` toggle in the same cycle and are always complementary.
- `restart` sampled high at edge N: `pll_rst`=1 and `core_reset`=1 from N+1.

## Configuration
- PLL_SEQ_TIMEOUT_EN defined:
  - Timeout logic is present, as described above.
- PLL_SEQ_TIMEOUT_EN undefined:
  - The `tmo_cnt` comparator is removed.
  - WAIT_LOCK and STABILIZE wait indefinitely.
  - `retry_count` is tied to 0.
  - All other behaviour is unchanged.

## Test plan
Bench parameters: RST_CYCLES=4, STABLE_CYCLES=8, TIMEOUT_CYCLES=32, macro defined.
- Release `rst`, raise `locked` at cycle 10 → `pll_rst` low after 4 cycles; `ready`=1 exactly 11 cycles after `locked` is sampled; `retry_count`=0.
- `locked` glitches low for 1 cycle during STABILIZE → stays in WAIT_LOCK/STABILIZE; `ready` rises 11 cycles after the final rising edge.
- `locked` held 0 → timeout every 36 cycles; `retry_count` counts 1, 2, 3…; verify it saturates at 255 after forced long run.
- In RUN, drop `locked` → `lock_lost` single pulse and `core_reset`=1 3 cycles later; `pll_rst` high for 4 cycles; recovery when `locked` returns.
- `restart` pulse in RUN, and again 2 cycles into RESET_PLL → `pll_rst` stays high 4 cycles after the second pulse; `lock_lost`=0; `retry_count` unchanged.
- Assert `rst` mid-STABILIZE with `retry_count`=2 → all outputs at reset values the next cycle; `retry_count`=0. Repeat with macro undefined: no timeout after 1000 cycles of `locked`=0.

Source files
------------

// File: rtl/pll_reset_sequencer.sv
// PLL reset and lock-qualification sequencer in the refclk domain.
// Optional timeout/retry logic is enabled by defining PLL_SEQ_TIMEOUT_EN.
module pll_reset_sequencer #(
  parameter int RST_CYCLES     = 16,
  parameter int STABLE_CYCLES  = 1024,
  parameter int TIMEOUT_CYCLES = 742500,
  parameter int CNT_W          = 20
) (
  input  logic       refclk,
  input  logic       rst,
  input  logic       locked,
  input  logic       restart,
  output logic       pll_rst,
  output logic       core_reset,
  output logic       ready,
  output logic       lock_lost,
  output logic [7:0] retry_count,
  output logic [1:0] state
);

  localparam logic [1:0] RESET_PLL = 2'd0;
  localparam logic [1:0] WAIT_LOCK = 2'd1;
  localparam logic [1:0] STABILIZE = 2'd2;
  localparam logic [1:0] RUN       = 2'd3;

  localparam logic [CNT_W-1:0] RST_LAST = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] STB_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic             lock_meta;
  logic             lock_s;
  logic [1:0]       state_d;
  logic [CNT_W-1:0] seq_cnt;    // RST_CYCLES count in RESET_PLL, timeout count after
  logic [CNT_W-1:0] seq_cnt_d;
  logic [CNT_W-1:0] stb_cnt;
  logic [CNT_W-1:0] stb_cnt_d;
  logic [CNT_W-1:0] tmo_next;
  logic             lost_d;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values, independent of block ordering in simulation.
  always_ff @(posedge refclk) begin
    if (rst) begin
      lock_meta <= 1'b0;
      lock_s    <= 1'b0;
    end else begin
      lock_meta <= locked;
      lock_s    <= lock_meta;
    end
  end

`ifdef PLL_SEQ_TIMEOUT_EN
  logic       tmo_hit;
  logic [7:0] retry_q;

  assign tmo_next = seq_cnt + 1'b1;
  assign tmo_hit  = ((state == WAIT_LOCK) || (state == STABILIZE)) && (seq_cnt == TMO_LAST);

  // A restart in the same cycle wins over the timeout, so it is not counted.
  always_ff @(posedge refclk) begin
    if (rst) begin
      retry_q <= 8'd0;
    end else if (tmo_hit && !restart && (retry_q != 8'hFF)) begin
      retry_q <= retry_q + 8'd1;
    end
  end

  assign retry_count = retry_q;
`else
  // Nothing acts on the count here; holding at the top keeps it from wrapping.
  assign tmo_next    = (seq_cnt == TMO_LAST) ? seq_cnt : seq_cnt + 1'b1;
  assign retry_count = 8'd0;
`endif

  // NOTE: every variable driven here gets a default first, so no path leaves
  // one unassigned and no latch is inferred.
  always_comb begin
    state_d   = state;
    seq_cnt_d = seq_cnt;
    stb_cnt_d = stb_cnt;
    lost_d    = 1'b0;

    case (state)
      RESET_PLL: begin
        if (seq_cnt == RST_LAST) begin
          state_d   = WAIT_LOCK;
          seq_cnt_d = '0;
        end else begin
          seq_cnt_d = seq_cnt + 1'b1;
        end
      end
      WAIT_LOCK: begin
        seq_cnt_d = tmo_next;
        if (lock_s) begin
          state_d   = STABILIZE;
          stb_cnt_d = '0;
        end
      end
      STABILIZE: begin
        seq_cnt_d = tmo_next;
        if (!lock_s) begin
          state_d = WAIT_LOCK;
        end else if (stb_cnt == STB_LAST) begin
          state_d = RUN;
        end else begin
          stb_cnt_d = stb_cnt + 1'b1;
        end
      end
      default: begin
        if (!lock_s) begin
          lost_d    = 1'b1;
          state_d   = RESET_PLL;
          seq_cnt_d = '0;
        end
      end
    endcase

`ifdef PLL_SEQ_TIMEOUT_EN
    if (tmo_hit) begin
      state_d   = RESET_PLL;
      seq_cnt_d = '0;
    end
`endif

    // lock_lost is deliberately left alone so a coincident loss still reports.
    if (restart) begin
      state_d   = RESET_PLL;
      seq_cnt_d = '0;
    end
  end

  // Outputs are decoded from the next state so they change with the state register.
  always_ff @(posedge refclk) begin
    if (rst) begin
      state      <= RESET_PLL;
      seq_cnt    <= '0;
      stb_cnt    <= '0;
      pll_rst    <= 1'b1;
      core_reset <= 1'b1;
      ready      <= 1'b0;
      lock_lost  <= 1'b0;
    end else begin
      state      <= state_d;
      seq_cnt    <= seq_cnt_d;
      stb_cnt    <= stb_cnt_d;
      pll_rst    <= (state_d == RESET_PLL);
      core_reset <= (state_d != RUN);
      ready      <= (state_d == RUN);
      lock_lost  <= lost_d;
    end
  end

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Directed self-checking bench for pll_reset_sequencer (RST=4, STABLE=8, TIMEOUT=32).
// Timeout/retry expectations apply when PLL_SEQ_TIMEOUT_EN is defined.
module tb_pll_reset_sequencer;

  logic       refclk = 1'b0;
  logic       rst = 1'b1;
  logic       locked = 1'b0;
  logic       restart = 1'b0;
  logic       pll_rst;
  logic       core_reset;
  logic       ready;
  logic       lock_lost;
  logic [7:0] retry_count;
  logic [1:0] state;

  int vectors = 0;
  int miscompares = 0;

  localparam logic [1:0] S_RESET = 2'd0;
  localparam logic [1:0] S_WAIT  = 2'd1;
  localparam logic [1:0] S_STAB  = 2'd2;
  localparam logic [1:0] S_RUN   = 2'd3;

  pll_reset_sequencer #(
    .RST_CYCLES(4),
    .STABLE_CYCLES(8),
    .TIMEOUT_CYCLES(32),
    .CNT_W(20)
  ) dut (
    .refclk(refclk),
    .rst(rst),
    .locked(locked),
    .restart(restart),
    .pll_rst(pll_rst),
    .core_reset(core_reset),
    .ready(ready),
    .lock_lost(lock_lost),
    .retry_count(retry_count),
    .state(state)
  );

  always #5 refclk = ~refclk;

  // Advance n rising edges; outputs are then sampled 1 time unit after the edge.
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge refclk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, ".pll_rst"}, 32'(pll_rst), 32'd1);
    check({tag, ".core_reset"}, 32'(core_reset), 32'd1);
    check({tag, ".ready"}, 32'(ready), 32'd0);
    check({tag, ".lock_lost"}, 32'(lock_lost), 32'd0);
    check({tag, ".retry"}, 32'(retry_count), 32'd0);
    check({tag, ".state"}, 32'(state), 32'(S_RESET));
  endtask

  initial begin
    // Reset state
    tick(3);
    check_reset_values("reset");

    // Power-up: pll_rst covers the first 4 cycles with rst low
    rst = 1'b0;
    tick(3);
    check("pwr.pll_rst_hi", 32'(pll_rst), 32'd1);
    tick(1);
    check("pwr.pll_rst_lo", 32'(pll_rst), 32'd0);
    check("pwr.state_wait", 32'(state), 32'(S_WAIT));

    // Lock arrives at cycle 10; ready exactly 11 edges later
    tick(6);
    locked = 1'b1;
    tick(3);
    check("lock.state_stab", 32'(state), 32'(S_STAB));
    tick(7);
    check("lock.ready_early", 32'(ready), 32'd0);
    tick(1);
    check("lock.ready", 32'(ready), 32'd1);
    check("lock.core_reset", 32'(core_reset), 32'd0);
    check("lock.state_run", 32'(state), 32'(S_RUN));
    check("lock.retry", 32'(retry_count), 32'd0);

    // Lock loss in RUN: lock_lost/core_reset three edges later, pll_rst for 4 cycles
    locked = 1'b0;
    tick(2);
    check("loss.ready_held", 32'(ready), 32'd1);
    check("loss.lost_early", 32'(lock_lost), 32'd0);
    tick(1);
    check("loss.lock_lost", 32'(lock_lost), 32'd1);
    check("loss.core_reset", 32'(core_reset), 32'd1);
    check("loss.ready", 32'(ready), 32'd0);
    check("loss.pll_rst", 32'(pll_rst), 32'd1);
    tick(1);
    check("loss.lost_pulse_end", 32'(lock_lost), 32'd0);
    tick(2);
    check("loss.pll_rst_4th", 32'(pll_rst), 32'd1);
    tick(1);
    check("loss.pll_rst_lo", 32'(pll_rst), 32'd0);
    locked = 1'b1;
    tick(10);
    check("recov.ready_early", 32'(ready), 32'd0);
    tick(1);
    check("recov.ready", 32'(ready), 32'd1);

    // Restart in RUN, then again two cycles into RESET_PLL
    restart = 1'b1;
    tick(1);
    restart = 1'b0;
    check("rs1.pll_rst", 32'(pll_rst), 32'd1);
    check("rs1.core_reset", 32'(core_reset), 32'd1);
    check("rs1.lock_lost", 32'(lock_lost), 32'd0);
    tick(2);
    restart = 1'b1;
    tick(1);
    restart = 1'b0;
    tick(3);
    check("rs2.pll_rst_hi", 32'(pll_rst), 32'd1);
    check("rs2.state", 32'(state), 32'(S_RESET));
    tick(1);
    check("rs2.pll_rst_lo", 32'(pll_rst), 32'd0);
    check("rs2.lock_lost", 32'(lock_lost), 32'd0);
    check("rs2.retry", 32'(retry_count), 32'd0);
    tick(1);
    check("rs2.state_stab", 32'(state), 32'(S_STAB));

    // One-cycle glitch on locked during STABILIZE
    tick(2);
    locked = 1'b0;
    tick(1);
    locked = 1'b1;
    tick(1);
    check("glitch.still_stab", 32'(state), 32'(S_STAB));
    tick(1);
    check("glitch.back_wait", 32'(state), 32'(S_WAIT));
    tick(1);
    check("glitch.restab", 32'(state), 32'(S_STAB));
    tick(7);
    check("glitch.ready_early", 32'(ready), 32'd0);
    tick(1);
    check("glitch.ready", 32'(ready), 32'd1);

`ifdef PLL_SEQ_TIMEOUT_EN
    // Lock held low: first timeout 39 edges after the drop, then every 36
    locked = 1'b0;
    tick(38);
    check("tmo1.retry_early", 32'(retry_count), 32'd0);
    check("tmo1.state_wait", 32'(state), 32'(S_WAIT));
    tick(1);
    check("tmo1.retry", 32'(retry_count), 32'd1);
    check("tmo1.state", 32'(state), 32'(S_RESET));
    check("tmo1.pll_rst", 32'(pll_rst), 32'd1);
    check("tmo1.lock_lost", 32'(lock_lost), 32'd0);
    tick(36);
    check("tmo2.retry", 32'(retry_count), 32'd2);

    // rst mid-STABILIZE with retry_count = 2
    locked = 1'b1;
    tick(5);
    check("rstmid.state_stab", 32'(state), 32'(S_STAB));
    check("rstmid.retry_before", 32'(retry_count), 32'd2);
    rst = 1'b1;
    tick(1);
    check_reset_values("rstmid");

    // Timeout sequence from rst release; restart coinciding with the 3rd timeout
    locked = 1'b0;
    rst = 1'b0;
    tick(72);
    check("sat.retry2", 32'(retry_count), 32'd2);
    tick(35);
    restart = 1'b1;
    tick(1);
    restart = 1'b0;
    check("tmo_rs.retry_held", 32'(retry_count), 32'd2);
    check("tmo_rs.state", 32'(state), 32'(S_RESET));
    tick(36);
    check("sat.retry3", 32'(retry_count), 32'd3);
    tick(9071);
    check("sat.retry254", 32'(retry_count), 32'd254);
    tick(1);
    check("sat.retry255", 32'(retry_count), 32'd255);
    tick(72);
    check("sat.retry_held", 32'(retry_count), 32'd255);
`else
    // Without the timeout: 1000 cycles of no lock never leave WAIT_LOCK
    locked = 1'b0;
    tick(7);
    tick(1000);
    check("notmo.state", 32'(state), 32'(S_WAIT));
    check("notmo.pll_rst", 32'(pll_rst), 32'd0);
    check("notmo.core_reset", 32'(core_reset), 32'd1);
    check("notmo.retry", 32'(retry_count), 32'd0);

    locked = 1'b1;
    tick(4);
    check("rstmid.state_stab", 32'(state), 32'(S_STAB));
    rst = 1'b1;
    tick(1);
    check_reset_values("rstmid");
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
